// File: rtl/lsu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared types and helpers for the load/store byte sequencer.
// Revision: 1.0
// ---------------------------------------------------------------------------
package lsu_pkg;

  // Access size as encoded on address_mode (2'b11 is folded into SZ_WORD)
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    DONE  = 2'b11
  } lsu_state_e;

  // Number of bytes moved for a given address_mode value
  function automatic logic [2:0] size_to_bytes(input logic [1:0] mode);
    case (mode)
      2'b00:   size_to_bytes = 3'd1;
      2'b01:   size_to_bytes = 3'd2;
      default: size_to_bytes = 3'd4;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ---------------------------------------------------------------------------
// load_extend
// Sign/zero extension of an assembled little-endian load value.
// Purely combinational so the writeback mux can reuse it.
// Revision: 1.0
// ---------------------------------------------------------------------------
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] data,
  input  size_e       size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  // Replicate the top valid bit (or zero) above the access width
  always_comb begin
    result = data;
    case (size)
      SZ_BYTE: result = {{24{~is_unsigned & data[7]}},  data[7:0]};
      SZ_HALF: result = {{16{~is_unsigned & data[15]}}, data[15:0]};
      default: result = data;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_byte_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lsu_byte_sequencer
// Splits byte/half/word loads and stores into consecutive little-endian
// byte accesses on a byte-wide synchronous RAM, assembling and extending
// load results. Any alignment is allowed; addresses wrap at the RAM top.
// Revision: 1.0
// ---------------------------------------------------------------------------
module lsu_byte_sequencer
  import lsu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // core side
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            address_mode,
  input  logic                  req_unsigned,
  input  logic [WIDTH-1:0]      req_addr,
  input  logic [WIDTH-1:0]      req_wdata,
  output logic                  rsp_valid,
  output logic [WIDTH-1:0]      rsp_rdata,
  // memory side
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata
);

  lsu_state_e            state;
  logic                  is_store;
  logic                  is_unsigned;
  size_e                 size_r;
  logic [1:0]            last_k;     // N-1
  logic [1:0]            k;          // byte currently issued
  logic [ADDR_WIDTH-1:0] base;
  logic [WIDTH-1:0]      wdata_r;
  logic [WIDTH-1:0]      asm_data;   // load assembly register
  logic [WIDTH-1:0]      extended;

  // Upper address bits are outside the RAM and intentionally dropped
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[WIDTH-1:ADDR_WIDTH];

  // Sequencer: accepts in IDLE, walks bytes in ISSUE, captures the final
  // read byte in WAIT and pulses the response in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      is_store    <= 1'b0;
      is_unsigned <= 1'b0;
      size_r      <= SZ_BYTE;
      last_k      <= 2'd0;
      k           <= 2'd0;
      base        <= '0;
      wdata_r     <= '0;
      asm_data    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            is_store    <= req_we;
            is_unsigned <= req_unsigned;
            size_r      <= (address_mode == 2'b11) ? SZ_WORD : size_e'(address_mode);
            last_k      <= 2'(size_to_bytes(address_mode) - 3'd1);
            base        <= req_addr[ADDR_WIDTH-1:0];
            wdata_r     <= req_wdata;
            k           <= 2'd0;
            asm_data    <= '0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          // Read data lags issue by one cycle, so byte k-1 lands now
          if (!is_store && (k != 2'd0)) begin
            asm_data[{k - 2'd1, 3'b000} +: 8] <= mem_rdata;
          end
          if (k == last_k) begin
            state <= is_store ? DONE : WAIT;
          end else begin
            k <= k + 2'd1;
          end
        end
        WAIT: begin
          asm_data[{last_k, 3'b000} +: 8] <= mem_rdata;
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  load_extend u_load_extend (
    .data        (asm_data),
    .size        (size_r),
    .is_unsigned (is_unsigned),
    .result      (extended)
  );

  // Outputs decoded from registered state only; zero whenever inactive
  always_comb begin
    req_ready = (state == IDLE);
    mem_en    = (state == ISSUE);
    mem_we    = (state == ISSUE) && is_store;
    mem_addr  = (state == ISSUE) ? (base + ADDR_WIDTH'(k)) : '0;
    mem_wdata = ((state == ISSUE) && is_store) ? wdata_r[{k, 3'b000} +: 8] : 8'h00;
    rsp_valid = (state == DONE);
    rsp_rdata = ((state == DONE) && !is_store) ? extended : '0;
  end

endmodule
`default_nettype wire

// File: doc/lsu_byte_sequencer.md
# lsu_byte_sequencer

Load/store sequencer between the single-cycle core's ALU/store-data path and a byte-wide synchronous data RAM (2^17 bytes). Accepts one load or store of byte, halfword or word size per request and splits it into consecutive little-endian byte accesses. Word/halfword accesses are allowed at any alignment. For loads, it assembles the result and sign- or zero-extends it before handing it to the writeback mux. The core stalls on `req_ready` while an access is in flight.

## Interface
- `WIDTH`, 32, core data width; fixed at 32.
- `ADDR_WIDTH`, 17, byte-address width of the RAM.

Clock and reset:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; **asynchronous, active-low**.

Core side:
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE; accept = `req_valid && req_ready`.
- `req_we`  in  1  1 = store, 0 = load.
- `address_mode`  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
- `req_unsigned`  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- `req_addr`  in  WIDTH  byte address; only the low ADDR_WIDTH bits are used.
- `req_wdata`  in  WIDTH  store data; only the low N bytes are used.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  WIDTH  extended load data; 0 after a store.

Memory side:
- `mem_en`  out  1  byte access this cycle.
- `mem_we`  out  1  write strobe.
- `mem_addr`  out  ADDR_WIDTH  byte address.
- `mem_wdata`  out  8  byte to write.
- `mem_rdata`  in  8  read byte; valid the cycle after a read issue.

## Operation
- N = 1, 2 or 4 bytes, per `address_mode`.
- On accept, register the operation, size, sign mode, address and data; clear the byte counter k and the assembly register.
- States:
  - IDLE: on accept, go to ISSUE.
  - ISSUE: drive byte k. Stay while k < N-1. When k = N-1, a store goes to DONE and a load goes to WAIT.
  - WAIT (loads only): capture the last byte, then go to DONE.
  - DONE: `rsp_valid` = 1, then go to IDLE.
- In ISSUE:
  - `mem_en` = 1.
  - `mem_addr` = (base + k) mod 2^ADDR_WIDTH; addresses wrap around the top of the RAM.
  - Stores: `mem_we` = 1 and `mem_wdata` = wdata[8k+7:8k].
  - Loads: `mem_we` = 0, and `mem_rdata` from the previous cycle's read goes into assembly bits [8(k-1)+7:8(k-1)].
- Load result: assembly bits above 8N are filled with bit 8N-1 when signed, or with zeros when unsigned. It is presented on `rsp_rdata` in DONE.
- `req_valid` and all request inputs are ignored outside IDLE; there is no queueing.
- Reset mid-operation: return to IDLE immediately with all outputs at their reset values. Bytes already written stay in RAM; no response is produced.

## Timing
- Reset values: `req_ready` = 1; `rsp_valid`, `rsp_rdata`, `mem_en`, `mem_we`, `mem_addr`, `mem_wdata` all = 0.
- All outputs are registered, or decoded from registered state only; there is no combinational path from input to output.
- Cycle numbering: accept at edge 0; the cycle after edge 0 is cycle 1.
- Byte k is issued in cycle k+1.
- Store: `rsp_valid` in cycle N+1, giving N+1 cycles of `req_ready` low.
- Load: WAIT in cycle N+1, `rsp_valid` in cycle N+2.
- IDLE resumes in the cycle after DONE. The earliest next accept is at the edge ending that IDLE cycle.

## Structure
- Shared package `lsu_pkg` holds:
  - `size_e` (`SZ_BYTE`=2'b00, `SZ_HALF`=2'b01, `SZ_WORD`=2'b10);
  - `lsu_state_e` (IDLE, ISSUE, WAIT, DONE);
  - function `size_to_bytes`.
- One sub-module: `load_extend`, purely combinational: assembled word + size + unsigned flag → 32-bit extended result. It is reusable by the writeback mux.

## Test plan
- LW at 0x100, RAM bytes 78,56,34,12 → `rsp_rdata` = 0x12345678 with `rsp_valid` in cycle 6; `mem_addr` sequence 0x100–0x103.
- LB at 0x20 holding 0x80 → 0xFFFFFF80; LBU at the same address → 0x00000080; each responds in cycle 3.
- SH 0x0000ABCD at 0x1FFFF → writes CD to 0x1FFFF, then AB to 0x00000 (wrap); `rsp_valid` in cycle 3 with `rsp_rdata` = 0.
- Misaligned SW 0xDEADBEEF at 0x3, then LW at 0x3 → reads back 0xDEADBEEF; bytes 0x3–0x6 = EF,BE,AD,DE.
- `req_valid` held high with changing data during a word load → only the first request is executed, `req_ready` stays low for 6 cycles, and the second request is accepted only after DONE.
- `rst_n` asserted in cycle 3 of SW 0x11223344 at 0x40 → outputs zero immediately and the block is in IDLE; RAM 0x40 = 44, 0x41 = 33, 0x42/0x43 unchanged; no `rsp_valid`.
